// File: rtl/alu_ex_stage.sv
// rtl/alu_ex_stage.sv - registered ALU execute stage with serial shifter (BARREL_SHIFT_EN selects single-cycle shifts)
module alu_ex_stage #(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     alu_result;
    logic [SHAMT_W-1:0]  shamt;
    logic                accept;

    assign shamt     = op_b[SHAMT_W-1:0];
    assign in_ready  = !flush && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign zero      = (result == '0);

`ifndef BARREL_SHIFT_EN
    logic [SHAMT_W-1:0]  cnt;
    logic                shift_right;
    logic                shift_arith;
    logic                start_serial;

    // Only shifts by a nonzero amount need the multi-cycle path.
    assign start_serial = alu_op[4] && (alu_op[1:0] == 2'b01) && (shamt != '0);
`endif

    always_comb begin
        alu_result = op_b;
        if (alu_op[4]) begin
            case (alu_op[2:0])
                3'b000: alu_result = alu_op[3] ? (op_a - op_b) : (op_a + op_b);
`ifdef BARREL_SHIFT_EN
                3'b001: alu_result = op_a << shamt;
`else
                3'b001: alu_result = op_a;
`endif
                3'b010: alu_result = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                3'b011: alu_result = {{(XLEN-1){1'b0}}, (op_a < op_b)};
                3'b100: alu_result = op_a ^ op_b;
`ifdef BARREL_SHIFT_EN
                3'b101: begin
                    if (alu_op[3]) alu_result = $unsigned($signed(op_a) >>> shamt);
                    else           alu_result = op_a >> shamt;
                end
`else
                3'b101: alu_result = op_a;
`endif
                3'b110: alu_result = op_a | op_b;
                default: alu_result = op_a & op_b;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            result <= '0;
            rd_out <= '0;
`ifndef BARREL_SHIFT_EN
            cnt         <= '0;
            shift_right <= 1'b0;
            shift_arith <= 1'b0;
`endif
        end else if (flush) begin
            state <= IDLE;
        end else if (accept) begin
            rd_out <= rd_in;
`ifndef BARREL_SHIFT_EN
            if (start_serial) begin
                result      <= op_a;
                cnt         <= shamt;
                shift_right <= alu_op[2];
                shift_arith <= alu_op[3];
                state       <= BUSY;
            end else begin
                result <= alu_result;
                state  <= DONE;
            end
`else
            result <= alu_result;
            state  <= DONE;
`endif
        end else begin
            case (state)
`ifndef BARREL_SHIFT_EN
                BUSY: begin
                    if (shift_right)
                        result <= {shift_arith & result[XLEN-1], result[XLEN-1:1]};
                    else
                        result <= {result[XLEN-2:0], 1'b0};
                    cnt <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) state <= DONE;
                end
`endif
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= state;
            endcase
        end
    end

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Registered execute stage directly downstream of the ALU-opcode decoder.
- Consumes the 5-bit ALU opcode, laid out as [use_alu][funct7 bit][funct3], plus two 32-bit operands; produces a registered result and a zero flag for branch resolution.
- Shifts use an area-saving serial shifter, one bit per cycle, behind a valid/ready handshake on both sides.
- A synchronous flush kills in-flight work on branch redirect.

Parameters:
- XLEN, 32, operand/result width.
- SHAMT_W, 5, shift-amount width (log2 XLEN).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous kill of held/in-flight operation.
- in_valid  in  1  upstream has an operation.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  5  [4]=use ALU (0 → pass op_b), [3]=sub/sra select, [2:0]=funct3.
- op_a  in  XLEN  operand A (rs1).
- op_b  in  XLEN  operand B (rs2 or immediate); shamt = op_b[SHAMT_W-1:0].
- rd_in  in  5  destination register tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  XLEN  registered result.
- zero  out  1  result == 0.
- rd_out  out  5  tag travelling with result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; out_valid=0, result=0, zero=1, rd_out=0, shift counter=0. in_ready is 1 once reset deasserts.
- States:
  - IDLE: no held result.
  - BUSY: serial shift in progress.
  - DONE: result held, out_valid=1.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is 0 in BUSY and 0 whenever flush=1.
- Accept = in_valid & in_ready.
- Decode on accept when alu_op[4]=1:
  - 000: add, or sub if [3].
  - 001: sll.
  - 010: slt, signed.
  - 011: sltu.
  - 100: xor.
  - 101: srl, or sra if [3].
  - 110: or.
  - 111: and.
- alu_op[4]=0: result=op_b (loads, stores, lui paths).
- Arithmetic wraps modulo 2^XLEN; no overflow flag. slt/sltu produce 0 or 1 zero-extended.
- Non-shift, or shift with shamt=0: result is registered on the accept edge and the stage enters DONE. Latency 1 cycle.
- Shift with shamt=n>0: the accept edge loads op_a into result and n into the counter, and the stage enters BUSY.
  - Each BUSY edge shifts by 1 (sra replicates bit XLEN-1) and decrements the counter.
  - When the counter goes 1→0, the stage enters DONE.
  - out_valid rises n+1 cycles after the accept cycle.
- DONE:
  - Holds result, zero and rd_out stable while out_ready=0.
  - out_ready=1 with no accept → IDLE.
  - out_ready=1 with a same-cycle accept → back-to-back: the new op loads and there is no bubble.
- zero is combinationally derived from the registered result; it is valid whenever out_valid=1.
- Flush: next state is IDLE, out_valid=0, and any in-progress shift is discarded. Flush overrides a simultaneous accept (the new op is not taken) and a simultaneous out_ready.
- rd_out is captured on accept.
- Output data is don't-care while out_valid=0, but registers are not cleared except by reset.

Optional Feature:
- BARREL_SHIFT_EN
- Defined: shifts compute in a single-cycle barrel shifter. All ops have latency 1 and BUSY is unreachable; the counter is removed.
- Undefined: serial shifter as described above, latency 1+shamt cycles.

Test Plan:
- Add then sub with out_ready=1:
  - alu_op=10000, a=7, b=5 → result=12, zero=0, 1 cycle later.
  - alu_op=11000, a=5, b=5 → result=0, zero=1.
- slt vs sltu:
  - a=FFFFFFFF, b=1, alu_op=10010 → result=1.
  - alu_op=10011 → result=0.
- sra with serial shift: a=80000000, b=4, alu_op=11101 → in_ready=0 for 4 cycles, out_valid on the 5th cycle, result=F8000000. srl of the same operands → 08000000.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles after a result → result stable, in_ready=0.
  - Raise out_ready with in_valid=1 (xor a=F0F0F0F0, b=FFFFFFFF) → next-cycle result=0F0F0F0F, no bubble.
- Flush mid-shift: sll a=1, b=31; assert flush at BUSY cycle 10 with in_valid=1 → next cycle out_valid=0, state IDLE, the offered op not accepted.
- Reset mid-operation: drop rst_n during BUSY → outputs zeroed immediately; after release a pass-through op (alu_op=00000, b=DEADBEEF) → result=DEADBEEF.
